idli_sqi_ctrl_m: RTL and testbench

Core-side initiator for the external SQI serial SRAMs that source the nibble stream consumed by decode and the vop expander, and that sink the stores those expanded ops produce. It turns a held read or write request into the SRAM's sequential-mode SQI framing: command, 16-bit address, dummy cycles for reads, then an unbounded data stream. Read nibbles are returned one per cycle; write nibbles are taken one per cycle. The block owns chip select and the SIO pad direction.

---
 rtl/idli_sqi_ctrl_m.sv | 159 +++++++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// SQI sequential-mode SRAM initiator: cmd, 16-bit addr, dummy (reads), then an unbounded nibble stream.
// Registered pads; read nibbles land one cycle after the pad, write nibbles go out the cycle after wr_rdy.
module idli_sqi_ctrl_m (
   input  logic        i_sqi_gck,
   input  logic        i_sqi_rst_n,
   input  logic        i_sqi_req_vld,
   input  logic        i_sqi_req_wr,
   input  logic [15:0] i_sqi_req_addr,
   input  logic [3:0]  i_sqi_wr_data,
   output logic        o_sqi_wr_rdy,
   output logic [3:0]  o_sqi_rd_data,
   output logic        o_sqi_rd_vld,
   output logic        o_sqi_busy,
   output logic        o_sqi_cs_n,
   output logic [3:0]  o_sqi_sio,
   output logic        o_sqi_sio_oe,
   input  logic [3:0]  i_sqi_sio
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_ADDR  = 3'd2,
      S_DUMMY = 3'd3,
      S_DATA  = 3'd4,
      S_END   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nxt;
   logic        r_wr;
   logic [15:0] r_addr;

   logic        r_cs_n;
   logic        r_sio_oe;
   logic [3:0]  r_sio;
   logic        r_rd_vld;
   logic [3:0]  r_rd_data;
   logic        r_busy;

   logic        w_cs_n_nxt;
   logic        w_oe_nxt;
   logic [3:0]  w_sio_nxt;
   logic        w_rd_vld_nxt;
   logic [3:0]  w_addr_nib;

   // Request drop wins over every sequencing step; END always returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_sqi_req_vld) w_state_nxt = S_CMD;
         S_CMD: begin
            if (!i_sqi_req_vld)      w_state_nxt = S_END;
            else if (r_cnt == 3'd1)  w_state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (!i_sqi_req_vld)      w_state_nxt = S_END;
            else if (r_cnt == 3'd3)  w_state_nxt = r_wr ? S_DATA : S_DUMMY;
         end
         S_DUMMY: begin
            if (!i_sqi_req_vld)      w_state_nxt = S_END;
            else if (r_cnt == 3'd1)  w_state_nxt = S_DATA;
         end
         S_DATA:  if (!i_sqi_req_vld) w_state_nxt = S_END;
         S_END:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      w_cnt_nxt = r_cnt;
      if (w_state_nxt != r_state)
         w_cnt_nxt = 3'd0;
      else if (r_state == S_CMD || r_state == S_ADDR || r_state == S_DUMMY)
         w_cnt_nxt = r_cnt + 3'd1;

      case (w_cnt_nxt[1:0])
         2'd0:    w_addr_nib = r_addr[15:12];
         2'd1:    w_addr_nib = r_addr[11:8];
         2'd2:    w_addr_nib = r_addr[7:4];
         default: w_addr_nib = r_addr[3:0];
      endcase

      // Pad values are computed for the state being entered so they register alongside it.
      w_cs_n_nxt   = 1'b1;
      w_oe_nxt     = 1'b0;
      w_sio_nxt    = 4'h0;
      w_rd_vld_nxt = 1'b0;
      case (w_state_nxt)
         S_CMD: begin
            w_cs_n_nxt = 1'b0;
            w_oe_nxt   = 1'b1;
            w_sio_nxt  = (w_cnt_nxt == 3'd0) ? 4'h0 : {3'b001, ~r_wr};
         end
         S_ADDR: begin
            w_cs_n_nxt = 1'b0;
            w_oe_nxt   = 1'b1;
            w_sio_nxt  = w_addr_nib;
         end
         S_DUMMY: w_cs_n_nxt = 1'b0;
         S_DATA: begin
            w_cs_n_nxt = 1'b0;
            if (r_wr) begin
               w_oe_nxt  = 1'b1;
               w_sio_nxt = i_sqi_wr_data;
            end else begin
               w_rd_vld_nxt = (r_state == S_DATA);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         r_wr      <= 1'b0;
         r_addr    <= 16'h0;
         r_cs_n    <= 1'b1;
         r_sio_oe  <= 1'b0;
         r_sio     <= 4'h0;
         r_rd_vld  <= 1'b0;
         r_rd_data <= 4'h0;
         r_busy    <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_sqi_req_vld) begin
            r_wr   <= i_sqi_req_wr;
            r_addr <= i_sqi_req_addr;
         end
         r_cs_n   <= w_cs_n_nxt;
         r_sio_oe <= w_oe_nxt;
         r_sio    <= w_sio_nxt;
         r_rd_vld <= w_rd_vld_nxt;
         if (w_rd_vld_nxt)
            r_rd_data <= i_sqi_sio;
         r_busy   <= (w_state_nxt != S_IDLE);
      end
   end

   // The last ADDR cycle already accepts a nibble so it is on the pads in the first DATA cycle.
   assign o_sqi_wr_rdy  = i_sqi_req_vld && r_wr &&
                          ((r_state == S_DATA) || (r_state == S_ADDR && r_cnt == 3'd3));
   assign o_sqi_rd_data = r_rd_data;
   assign o_sqi_rd_vld  = r_rd_vld;
   assign o_sqi_busy    = r_busy;
   assign o_sqi_cs_n    = r_cs_n;
   assign o_sqi_sio     = r_sio;
   assign o_sqi_sio_oe  = r_sio_oe;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: SQI SRAM pad model plus queue scoreboard against a byte-array reference memory.
module tb_idli_sqi_ctrl_m;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = 16'h0;
   logic [3:0]  wr_data = 4'h0;
   logic [3:0]  sio_in = 4'h0;
   logic        o_wr_rdy, o_rd_vld, o_busy, o_cs_n, o_oe;
   logic [3:0]  o_rd_data, o_sio;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int incomplete = 0;

   logic [7:0] ref_mem  [0:65535];
   logic [7:0] sram_mem [0:65535];

   typedef struct {int cyc; logic wr; logic [15:0] addr;} hdr_t;
   typedef struct {int cyc; logic [3:0] dat;} nib_t;
   hdr_t hdrq[$];
   nib_t rdq[$];
   nib_t wrq[$];
   nib_t wsq[$];
   logic [3:0] fixed_nib[$];

   idli_sqi_ctrl_m dut (
      .i_sqi_gck      (clk),
      .i_sqi_rst_n    (rst_n),
      .i_sqi_req_vld  (req),
      .i_sqi_req_wr   (req_wr),
      .i_sqi_req_addr (req_addr),
      .i_sqi_wr_data  (wr_data),
      .o_sqi_wr_rdy   (o_wr_rdy),
      .o_sqi_rd_data  (o_rd_data),
      .o_sqi_rd_vld   (o_rd_vld),
      .o_sqi_busy     (o_busy),
      .o_sqi_cs_n     (o_cs_n),
      .o_sqi_sio      (o_sio),
      .o_sqi_sio_oe   (o_oe),
      .i_sqi_sio      (sio_in)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic miss(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [3:0] nib_of(input logic [7:0] b, input int j);
      return (j % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   // SRAM pad model: decodes the header, supplies read data after two dummy cycles, stores write data.
   int          k = 0;
   logic [23:0] sh = 24'h0;
   logic        s_wr = 1'b0;
   logic [15:0] s_addr = 16'h0;
   logic [3:0]  s_tmp = 4'h0;
   always @(negedge clk) begin : sram
      hdr_t h;
      nib_t e;
      if (!o_cs_n) begin
         if (k < 6) begin
            chk("oe_header", 32'(o_oe), 32'd1);
            sh = {sh[19:0], o_sio};
            if (k == 5) begin
               s_wr   = (sh[23:16] == 8'h02);
               s_addr = sh[15:0];
               if (hdrq.size() == 0) miss("hdr_unexpected");
               else begin
                  h = hdrq.pop_front();
                  chk("hdr_cmd",   32'(sh[23:16]), h.wr ? 32'h02 : 32'h03);
                  chk("hdr_addr",  32'(sh[15:0]),  32'(h.addr));
                  chk("hdr_cycle", 32'(cyc - 5),   32'(h.cyc));
               end
            end
            sio_in = 4'($urandom);
         end else if (s_wr) begin
            chk("oe_wdata", 32'(o_oe), 32'd1);
            if (wsq.size() == 0) miss("wdata_unexpected");
            else begin
               e = wsq.pop_front();
               chk("wdata_cycle", 32'(cyc), 32'(e.cyc));
               chk("wdata_pad",   32'(o_sio), 32'(e.dat));
            end
            if ((k - 6) % 2 == 0) s_tmp = o_sio;
            else sram_mem[s_addr + 16'((k - 6) / 2)] = {s_tmp, o_sio};
            sio_in = 4'($urandom);
         end else begin
            chk("oe_rphase", 32'(o_oe), 32'd0);
            if (k >= 8) sio_in = nib_of(sram_mem[s_addr + 16'((k - 8) / 2)], k - 8);
            else        sio_in = 4'($urandom);
         end
         k++;
      end else begin
         if (k > 0 && k < 6) incomplete++;
         k = 0;
         chk("oe_deselected", 32'(o_oe), 32'd0);
         sio_in = 4'($urandom);
      end
   end

   // Output monitor: every rd_vld / wr_rdy must match the next scoreboard entry in cycle and data.
   always @(negedge clk) begin : mon
      nib_t e;
      if (o_rd_vld) begin
         if (rdq.size() == 0) miss("rd_vld_unexpected");
         else begin
            e = rdq.pop_front();
            chk("rd_cycle", 32'(cyc), 32'(e.cyc));
            chk("rd_data",  32'(o_rd_data), 32'(e.dat));
         end
      end
      if (o_wr_rdy) begin
         if (wrq.size() == 0) miss("wr_rdy_unexpected");
         else begin
            e = wrq.pop_front();
            chk("wr_rdy_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction accepted in the current cycle (c0). abort_at>0 drops req in cycle c0+abort_at;
   // rst_at>=0 pulses reset in that cycle; early re-raises req during END.
   task automatic txn(input logic wr, input logic [15:0] addr, input int nnib,
                      input int abort_at, input int rst_at, input bit early);
      int c0, drop, idx;
      logic [3:0] nb[$];
      hdr_t h;
      nib_t e;
      c0 = cyc;
      req = 1'b1;
      req_wr = wr;
      req_addr = addr;
      drop = (abort_at > 0) ? c0 + abort_at : c0 + (wr ? 6 : 9) + nnib;
      if (abort_at <= 0 || abort_at >= 6) begin
         h.cyc = c0 + 1; h.wr = wr; h.addr = addr;
         hdrq.push_back(h);
      end
      if (abort_at <= 0) begin
         for (int j = 0; j < nnib; j++) begin
            if (wr) begin
               if (fixed_nib.size() > 0) nb.push_back(fixed_nib[j]);
               else if (rst_at >= 0)     nb.push_back(nib_of(ref_mem[addr + 16'(j / 2)], j));
               else                      nb.push_back(4'($urandom));
               e.cyc = c0 + 6 + j; e.dat = nb[j]; wrq.push_back(e);
               e.cyc = c0 + 7 + j;                wsq.push_back(e);
            end else begin
               e.cyc = c0 + 10 + j;
               e.dat = nib_of(ref_mem[addr + 16'(j / 2)], j);
               rdq.push_back(e);
            end
         end
         if (wr)
            for (int j = 0; j + 1 < nnib; j += 2)
               ref_mem[addr + 16'(j / 2)] = {nb[j], nb[j + 1]};
      end
      wr_data = 4'($urandom);
      while (cyc != drop) begin
         tick();
         idx = cyc - c0 - 6;
         if (wr && idx >= 0 && idx < int'(nb.size())) wr_data = nb[idx];
         else wr_data = 4'($urandom);
         if (rst_at >= 0 && cyc - c0 == rst_at) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("arst_cs_n",   32'(o_cs_n),   32'd1);
            chk("arst_oe",     32'(o_oe),     32'd0);
            chk("arst_sio",    32'(o_sio),    32'd0);
            chk("arst_busy",   32'(o_busy),   32'd0);
            chk("arst_rd_vld", 32'(o_rd_vld), 32'd0);
            req = 1'b0;
            tick();
            tick();
            wrq.delete();
            wsq.delete();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
      end
      req = 1'b0;
      req_wr = 1'($urandom);
      req_addr = 16'($urandom);
      tick();
      @(negedge clk);
      chk("end_cs_n",   32'(o_cs_n),   32'd1);
      chk("end_oe",     32'(o_oe),     32'd0);
      chk("end_rd_vld", 32'(o_rd_vld), 32'd0);
      chk("end_busy",   32'(o_busy),   32'd1);
      if (early) req = 1'b1;
      tick();
      @(negedge clk);
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_cs_n", 32'(o_cs_n), 32'd1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin : main
      int inc0;
      logic        w;
      logic [15:0] a;
      int          ab;
      for (int i = 0; i < 65536; i++) begin
         ref_mem[i]  = 8'($urandom);
         sram_mem[i] = ref_mem[i];
      end
      ref_mem[16'h1234] = 8'hAB; sram_mem[16'h1234] = 8'hAB;
      ref_mem[16'h1235] = 8'hCD; sram_mem[16'h1235] = 8'hCD;

      tick(); tick(); tick();
      @(negedge clk);
      chk("rst_cs_n",    32'(o_cs_n),    32'd1);
      chk("rst_sio",     32'(o_sio),     32'd0);
      chk("rst_oe",      32'(o_oe),      32'd0);
      chk("rst_rd_data", 32'(o_rd_data), 32'd0);
      chk("rst_rd_vld",  32'(o_rd_vld),  32'd0);
      chk("rst_busy",    32'(o_busy),    32'd0);
      rst_n = 1'b1;
      tick();

      txn(1'b0, 16'h1234, 4, -1, -1, 1'b0);
      fixed_nib = '{4'h5, 4'hA, 4'h5, 4'hA};
      txn(1'b1, 16'hBEEF, 4, -1, -1, 1'b0);
      fixed_nib.delete();
      txn(1'b0, 16'hBEEF, 4, -1, -1, 1'b0);

      txn(1'b0, 16'h1234, 4, -1, -1, 1'b1);
      txn(1'b0, 16'h3000, 6, -1, -1, 1'b0);

      inc0 = incomplete;
      txn(1'b0, 16'h0100, 0, 4, -1, 1'b0);
      chk("abort_incomplete_cmd", 32'(incomplete), 32'(inc0 + 1));

      txn(1'b1, 16'h2000, 16, -1, 9, 1'b0);
      txn(1'b0, 16'h2000, 16, -1, -1, 1'b0);

      txn(1'b0, 16'hFFF0, 64, -1, -1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         w  = 1'($urandom);
         a  = ($urandom % 2 == 0) ? 16'($urandom) : 16'h4000 + 16'($urandom_range(0, 31));
         ab = ($urandom % 5 == 0) ? $urandom_range(1, w ? 6 : 8) : -1;
         txn(w, a, 2 * $urandom_range(1, 8), ab, -1, ($urandom % 3 == 0));
      end
      req = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      chk("left_rd",  32'(rdq.size()),  32'd0);
      chk("left_wr",  32'(wrq.size()),  32'd0);
      chk("left_wsq", 32'(wsq.size()),  32'd0);
      chk("left_hdr", 32'(hdrq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
